// File: rtl/rom_arb_pkg.sv
// Shared types for the cartridge ROM port arbiter: FSM states, requester ids,
// the per-requester holding register and byte-lane helpers.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } arb_state_e;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_COP = 1'b1;

   typedef struct packed {
      logic [23:0] addr;
      logic        word;
      logic        we_n;
      logic [15:0] d;
   } hold_t;

   // Byte reads return the lane chosen by the low address bit, zero-extended.
   function automatic logic [15:0] read_data(input logic word, input logic a0,
                                             input logic [15:0] q);
      if (word) return q;
      return {8'h00, (a0 ? q[15:8] : q[7:0])};
   endfunction

   // Byte writes replicate the byte on both lanes; the memory picks via addr[0].
   function automatic logic [15:0] write_data(input logic word, input logic [15:0] d);
      if (word) return d;
      return {d[7:0], d[7:0]};
   endfunction

endpackage

// File: rtl/rom_arb_slot.sv
// One requester's capture slot: one-deep holding register plus pending flag.
module rom_arb_slot
   import rom_arb_pkg::*;
(
   input  logic  mclk_i,
   input  logic  rst_n_i,
   input  logic  req_i,
   input  hold_t req_fields_i,
   input  logic  in_service_i,
   input  logic  grant_i,
   output logic  pending_o,
   output hold_t hold_o
);

   logic  pending_q, pending_d;
   hold_t hold_q, hold_d;
   logic  accept;

   // The held access must stay frozen while waiting and while on the ROM port.
   assign accept = req_i && !pending_q && !in_service_i;

   always_comb begin
      pending_d = pending_q;
      hold_d    = hold_q;
      if (grant_i) begin
         pending_d = 1'b0;
      end
      if (accept) begin
         pending_d = 1'b1;
         hold_d    = req_fields_i;
      end
   end

   always_ff @(posedge mclk_i) begin
      if (!rst_n_i) begin
         pending_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         pending_q <= pending_d;
         hold_q    <= hold_d;
      end
   end

   assign pending_o = pending_q;
   assign hold_o    = hold_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-requester (CPU, COP) arbiter for the single cartridge ROM port with
// fixed-latency accesses. Optional CPU streak limit: ROM_ARB_FAIRNESS_EN.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int MEM_LAT        = 4,
   parameter int MAX_CPU_STREAK = 3
) (
   input  logic        mclk,
   input  logic        rst_n,
   input  logic [23:0] rom_mask,
   input  logic        cpu_req,
   input  logic [23:0] cpu_addr,
   input  logic        cpu_word,
   input  logic        cpu_we_n,
   input  logic [15:0] cpu_d,
   output logic        cpu_ack,
   output logic [15:0] cpu_q,
   input  logic        cop_req,
   input  logic [23:0] cop_addr,
   input  logic        cop_word,
   input  logic        cop_we_n,
   input  logic [15:0] cop_d,
   output logic        cop_ack,
   output logic [15:0] cop_q,
   output logic [23:0] mem_addr,
   output logic [15:0] mem_d,
   input  logic [15:0] mem_q,
   output logic        mem_ce_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic        mem_word,
   output logic        busy
);

   arb_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        winner_q, winner_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_d_q, mem_d_d;
   logic        mem_word_q, mem_word_d;
   logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic        cpu_ack_q, cpu_ack_d, cop_ack_q, cop_ack_d;
   logic [15:0] cpu_q_q, cpu_q_d, cop_q_q, cop_q_d;

   logic [1:0]  req_v, pend_v, grant_v, serv_v;
   hold_t [1:0] in_v, hold_v;
   hold_t       grant_hold, serv_hold;
   logic        grant_cop;

   assign req_v         = {cop_req, cpu_req};
   assign in_v[REQ_CPU] = '{addr: cpu_addr, word: cpu_word, we_n: cpu_we_n, d: cpu_d};
   assign in_v[REQ_COP] = '{addr: cop_addr, word: cop_word, we_n: cop_we_n, d: cop_d};

   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign serv_v[gi] = (state_q == ACCESS) && (winner_q == 1'(gi));

      rom_arb_slot u_slot (
         .mclk_i       (mclk),
         .rst_n_i      (rst_n),
         .req_i        (req_v[gi]),
         .req_fields_i (in_v[gi]),
         .in_service_i (serv_v[gi]),
         .grant_i      (grant_v[gi]),
         .pending_o    (pend_v[gi]),
         .hold_o       (hold_v[gi])
      );
   end

`ifdef ROM_ARB_FAIRNESS_EN
   logic [7:0] streak_q, streak_d;

   // A waiting COP takes the slot once the CPU has used up its streak.
   assign grant_cop = pend_v[REQ_COP] &&
                      (!pend_v[REQ_CPU] || (streak_q == 8'(MAX_CPU_STREAK)));

   always_comb begin
      streak_d = streak_q;
      if ((state_q == IDLE) && (pend_v != 2'b00)) begin
         streak_d = (!grant_cop && pend_v[REQ_COP]) ? streak_q + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge mclk) begin
      if (!rst_n) streak_q <= '0;
      else        streak_q <= streak_d;
   end
`else
   logic unused_streak_cfg;
   assign unused_streak_cfg = ^32'(MAX_CPU_STREAK);
   assign grant_cop         = !pend_v[REQ_CPU];
`endif

   assign grant_hold = hold_v[grant_cop];
   assign serv_hold  = hold_v[winner_q];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      winner_d   = winner_q;
      mem_addr_d = mem_addr_q;
      mem_d_d    = mem_d_q;
      mem_word_d = mem_word_q;
      ce_n_d     = ce_n_q;
      oe_n_d     = oe_n_q;
      we_n_d     = we_n_q;
      cpu_ack_d  = 1'b0;
      cop_ack_d  = 1'b0;
      cpu_q_d    = cpu_q_q;
      cop_q_d    = cop_q_q;
      grant_v    = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (pend_v != 2'b00) begin
               grant_v[REQ_COP] = grant_cop;
               grant_v[REQ_CPU] = !grant_cop;
               winner_d   = grant_cop ? REQ_COP : REQ_CPU;
               state_d    = ACCESS;
               cnt_d      = 4'(MEM_LAT - 1);
               mem_addr_d = grant_hold.addr & rom_mask;
               mem_d_d    = write_data(grant_hold.word, grant_hold.d);
               mem_word_d = grant_hold.word;
               ce_n_d     = 1'b0;
               oe_n_d     = grant_hold.we_n;
               we_n_d     = !grant_hold.we_n;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               if (winner_q == REQ_CPU) begin
                  cpu_ack_d = 1'b1;
                  if (serv_hold.we_n) cpu_q_d = read_data(serv_hold.word, serv_hold.addr[0], mem_q);
               end else begin
                  cop_ack_d = 1'b1;
                  if (serv_hold.we_n) cop_q_d = read_data(serv_hold.word, serv_hold.addr[0], mem_q);
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         winner_q   <= REQ_CPU;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         mem_word_q <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         cpu_ack_q  <= 1'b0;
         cop_ack_q  <= 1'b0;
         cpu_q_q    <= '0;
         cop_q_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         winner_q   <= winner_d;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
         mem_word_q <= mem_word_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         cpu_ack_q  <= cpu_ack_d;
         cop_ack_q  <= cop_ack_d;
         cpu_q_q    <= cpu_q_d;
         cop_q_q    <= cop_q_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_d    = mem_d_q;
   assign mem_word = mem_word_q;
   assign mem_ce_n = ce_n_q;
   assign mem_oe_n = oe_n_q;
   assign mem_we_n = we_n_q;
   assign cpu_ack  = cpu_ack_q;
   assign cop_ack  = cop_ack_q;
   assign cpu_q    = cpu_q_q;
   assign cop_q    = cop_q_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: directed requests push expected
// acks/ROM windows; a negedge monitor pops and compares on every ack.
module tb_rom_port_arbiter;

   localparam int MEM_LAT = 4;

   logic        mclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] rom_mask = '0;
   logic        cpu_req = 1'b0, cpu_word = 1'b0, cpu_we_n = 1'b1;
   logic [23:0] cpu_addr = '0;
   logic [15:0] cpu_d = '0;
   logic        cop_req = 1'b0, cop_word = 1'b0, cop_we_n = 1'b1;
   logic [23:0] cop_addr = '0;
   logic [15:0] cop_d = '0;
   logic [15:0] mem_q = '0;
   logic        cpu_ack, cop_ack;
   logic [15:0] cpu_q, cop_q;
   logic [23:0] mem_addr;
   logic [15:0] mem_d;
   logic        mem_ce_n, mem_oe_n, mem_we_n, mem_word, busy;

   rom_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_CPU_STREAK(3)) dut (
      .mclk(mclk), .rst_n(rst_n), .rom_mask(rom_mask),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_word(cpu_word), .cpu_we_n(cpu_we_n),
      .cpu_d(cpu_d), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
      .cop_req(cop_req), .cop_addr(cop_addr), .cop_word(cop_word), .cop_we_n(cop_we_n),
      .cop_d(cop_d), .cop_ack(cop_ack), .cop_q(cop_q),
      .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q), .mem_ce_n(mem_ce_n),
      .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_word(mem_word), .busy(busy)
   );

   always #5 mclk = ~mclk;

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      bit          cop;
      logic [15:0] q;
      logic [23:0] addr;
      logic [15:0] d;
      logic        word;
      logic        we_n;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input bit cop, input logic [15:0] q, input logic [23:0] addr,
                               input logic [15:0] d, input logic word, input logic we_n,
                               input int c);
      exp_t e;
      e.cop = cop; e.q = q; e.addr = addr; e.d = d; e.word = word; e.we_n = we_n; e.cyc = c;
      return e;
   endfunction

   // ROM strobe window tracker plus ack scoreboard.
   logic        win_on = 1'b0, win_stable = 1'b0;
   int          win_len = 0;
   logic [23:0] win_addr = '0;
   logic [15:0] win_d = '0;
   logic        win_word = 1'b0, win_oe = 1'b1, win_we = 1'b1;

   always @(negedge mclk) begin
      exp_t e;
      if (!mem_ce_n) begin
         if (!win_on) begin
            win_on = 1'b1; win_len = 1; win_stable = 1'b1;
            win_addr = mem_addr; win_d = mem_d; win_word = mem_word;
            win_oe = mem_oe_n; win_we = mem_we_n;
         end else begin
            win_len++;
            if (mem_addr !== win_addr || mem_d !== win_d || mem_word !== win_word ||
                mem_oe_n !== win_oe || mem_we_n !== win_we) win_stable = 1'b0;
         end
      end else begin
         win_on = 1'b0;
      end
      if (cpu_ack || cop_ack) begin
         check("single_ack", 32'(cpu_ack & cop_ack), 0);
         check("ack_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("ack %s at cycle %0d q=%h addr=%h", cop_ack ? "COP" : "CPU", cyc,
                     cop_ack ? cop_q : cpu_q, win_addr);
            check("ack_who", 32'(cop_ack), 32'(e.cop));
            check("ack_q", cop_ack ? cop_q : cpu_q, e.q);
            if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
            check("busy_at_ack", busy, 1);
            check("ce_high_at_ack", mem_ce_n, 1);
            check("win_len", win_len, MEM_LAT);
            check("win_stable", win_stable, 1);
            check("win_addr", win_addr, e.addr);
            check("win_word", win_word, e.word);
            check("win_oe_n", win_oe, e.we_n);
            check("win_we_n", win_we, !e.we_n);
            if (!e.we_n) check("win_d", win_d, e.d);
         end
      end
   end

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic set_req(input bit cop, input logic [23:0] a, input logic w,
                          input logic wn, input logic [15:0] d);
      if (cop) begin
         cop_req = 1'b1; cop_addr = a; cop_word = w; cop_we_n = wn; cop_d = d;
      end else begin
         cpu_req = 1'b1; cpu_addr = a; cpu_word = w; cpu_we_n = wn; cpu_d = d;
      end
   endtask

   task automatic clr_req();
      cpu_req = 1'b0;
      cop_req = 1'b0;
   endtask

   task automatic wait_ack(input bit cop, input int limit, input string name);
      int n = 0;
      do begin
         @(negedge mclk);
         n++;
      end while (!(cop ? cop_ack : cpu_ack) && n < limit);
      check(name, 32'(cop ? cop_ack : cpu_ack), 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      repeat (10) tick();
   endtask

   initial begin
      int c;
      // Reset state
      repeat (3) tick();
      check("rst_ce_n", mem_ce_n, 1);
      check("rst_oe_n", mem_oe_n, 1);
      check("rst_we_n", mem_we_n, 1);
      check("rst_addr", mem_addr, 0);
      check("rst_d", mem_d, 0);
      check("rst_word", mem_word, 0);
      check("rst_acks", {cpu_ack, cop_ack}, 0);
      check("rst_cpu_q", cpu_q, 0);
      check("rst_cop_q", cop_q, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // CPU byte read, odd address -> high lane
      rom_mask = 24'h0FFFFF; mem_q = 16'hA55A;
      set_req(0, 24'h008001, 0, 1, 16'h0000);
      c = cyc;
      exp_q.push_back(mk(0, 16'h00A5, 24'h008001, 16'h0, 0, 1, c + MEM_LAT + 2));
      tick(); clr_req();
      drain("drain_byte_read");

      // Simultaneous requests: CPU word read then COP byte read (even lane)
      mem_q = 16'hC3D2;
      set_req(0, 24'h000100, 1, 1, 16'h0);
      set_req(1, 24'h200002, 0, 1, 16'h0);
      c = cyc;
      exp_q.push_back(mk(0, 16'hC3D2, 24'h000100, 16'h0, 1, 1, c + MEM_LAT + 2));
      exp_q.push_back(mk(1, 16'h00D2, 24'h000002, 16'h0, 0, 1, c + 2 * (MEM_LAT + 2)));
      tick(); clr_req();
      drain("drain_simultaneous");

      // COP word write: q must keep the previous read value
      rom_mask = 24'h3FFFFF; mem_q = 16'hFFFF;
      set_req(1, 24'h123456, 1, 0, 16'hBEEF);
      c = cyc;
      exp_q.push_back(mk(1, 16'h00D2, 24'h123456, 16'hBEEF, 1, 0, c + MEM_LAT + 2));
      tick(); clr_req();
      drain("drain_word_write");

      // CPU byte write, re-requests while pending and in service are ignored
      rom_mask = 24'h0FFFFF;
      set_req(0, 24'h0000A3, 0, 0, 16'h1277);
      c = cyc;
      exp_q.push_back(mk(0, 16'hC3D2, 24'h0000A3, 16'h7777, 0, 0, c + MEM_LAT + 2));
      tick(); set_req(0, 24'h0000B0, 1, 1, 16'h9999);
      tick(); clr_req();
      tick(); set_req(0, 24'h0000C0, 1, 1, 16'h5555);
      tick(); clr_req();
      drain("drain_repeat_req");

      // Reset during the second ACCESS cycle abandons the access
      mem_q = 16'h5AA5;
      set_req(0, 24'h000040, 1, 1, 16'h0);
      tick(); clr_req();
      tick(); tick();
      check("busy_in_access", busy, 1);
      check("ce_low_in_access", mem_ce_n, 0);
      rst_n = 1'b0;
      tick();
      check("midrst_ce_n", mem_ce_n, 1);
      check("midrst_oe_n", mem_oe_n, 1);
      check("midrst_we_n", mem_we_n, 1);
      check("midrst_ack", cpu_ack, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cpu_q", cpu_q, 0);
      rst_n = 1'b1;
      repeat (12) tick();
      check("post_rst_idle", busy, 0);
      set_req(0, 24'h0F0F0E, 1, 1, 16'h0);
      c = cyc;
      exp_q.push_back(mk(0, 16'h5AA5, 24'h0F0F0E, 16'h0, 1, 1, c + MEM_LAT + 2));
      tick(); clr_req();
      drain("drain_after_reset");

      // CPU re-requests on every ack while COP waits
      rom_mask = 24'hFFFFFF; mem_q = 16'h1234;
`ifdef ROM_ARB_FAIRNESS_EN
      for (int k = 0; k < 3; k++)
         exp_q.push_back(mk(0, 16'h1234, 24'h010000 + 24'(2 * k), 16'h0, 1, 1, -1));
      exp_q.push_back(mk(1, 16'h1234, 24'h020000, 16'h0, 1, 1, -1));
      for (int k = 3; k < 5; k++)
         exp_q.push_back(mk(0, 16'h1234, 24'h010000 + 24'(2 * k), 16'h0, 1, 1, -1));
`else
      for (int k = 0; k < 5; k++)
         exp_q.push_back(mk(0, 16'h1234, 24'h010000 + 24'(2 * k), 16'h0, 1, 1, -1));
      exp_q.push_back(mk(1, 16'h1234, 24'h020000, 16'h0, 1, 1, -1));
`endif
      set_req(0, 24'h010000, 1, 1, 16'h0);
      set_req(1, 24'h020000, 1, 1, 16'h0);
      tick(); clr_req();
      for (int k = 1; k < 5; k++) begin
         wait_ack(0, 40, "cpu_streak_ack");
         set_req(0, 24'h010000 + 24'(2 * k), 1, 1, 16'h0);
         tick(); clr_req();
      end
      drain("drain_streak");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single cartridge ROM memory port between two requesters: the SNES CPU-side mapper path (CPU) and a coprocessor path such as GSU, SA1 or SPC7110 decompression (COP).
- Each requester issues single-cycle request pulses. The arbiter buffers one pending request per requester, sequences fixed-latency accesses on the ROM port and returns read data with a one-cycle acknowledge.
- Sits between the mapper/coprocessor logic and the ROM_ADDR/ROM_Q/ROM_*_N pins of the top level.

Parameters:
- MEM_LAT, 4: cycles the ROM port strobes are held per access; legal range 2..15.
- MAX_CPU_STREAK, 3: consecutive CPU grants allowed while COP is pending. Used only with ROM_ARB_FAIRNESS_EN.

Ports:
- mclk  in  1  master clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rom_mask  in  24  address mask applied to every access.
- cpu_req  in  1  single-cycle request pulse.
- cpu_addr  in  24  byte address; sampled with cpu_req.
- cpu_word  in  1  1 = 16-bit access, 0 = byte; sampled with cpu_req.
- cpu_we_n  in  1  0 = write; sampled with cpu_req.
- cpu_d  in  16  write data; sampled with cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_q  out  16  read data; valid from cpu_ack, held until the next cpu_ack.
- cop_req, cop_addr, cop_word, cop_we_n, cop_d, cop_ack, cop_q: same as cpu_* for the COP requester.
- mem_addr  out  24  ROM port address.
- mem_d  out  16  ROM port write data.
- mem_q  in  16  ROM port read data.
- mem_ce_n  out  1  chip enable, active-low.
- mem_oe_n  out  1  output enable, active-low.
- mem_we_n  out  1  write enable, active-low.
- mem_word  out  1  word access flag.
- busy  out  1  high in ACCESS or DONE state.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; both pending flags cleared; streak counter = 0.
  - mem_ce_n, mem_oe_n, mem_we_n = 1; mem_addr, mem_d, mem_word = 0.
  - cpu_ack, cop_ack = 0; cpu_q, cop_q = 0; busy = 0.
  - Reset mid-access abandons the access; no ack is issued.
- Request capture:
  - On a req pulse with the same requester's pending flag clear and that requester not in service, latch addr/word/we_n/d into that requester's holding register and set pending.
  - A req while pending or in service is ignored; the holding register is not modified.
- State machine IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: if any pending flag is set, grant at the next edge. CPU wins over COP; a request captured in the same edge is eligible next cycle.
  - On grant, go to ACCESS and clear the winner's pending flag.
  - mem_addr = addr & rom_mask; mem_d = d; mem_word = word; mem_ce_n = 0; mem_oe_n = we_n; mem_we_n = ~we_n.
  - ACCESS: strobes held constant for exactly MEM_LAT cycles (counter MEM_LAT-1 down to 0). mem_q is sampled on the edge where the counter is 0; the state then moves to DONE.
  - DONE: all strobes = 1 (one turnaround cycle). The winner's ack = 1 for exactly this cycle. The winner's q is updated (reads only; writes leave q unchanged). Next state is IDLE.
- Byte reads: q = {8'h00, addr[0] ? mem_q[15:8] : mem_q[7:0]}.
- Byte writes: mem_d = {d[7:0], d[7:0]}; the memory uses addr[0] to select the lane.
- Timing:
  - Minimum latency, req pulse to ack: MEM_LAT+2 cycles.
  - Back-to-back: ack cycles are spaced MEM_LAT+2 cycles apart.
  - A new req may be pulsed in the same cycle as its own ack and is captured.
- Simultaneous events: both reqs in the same cycle, both captured; CPU served first, then COP.
- busy is high in ACCESS and DONE.

Optional Feature:
- Macro: ROM_ARB_FAIRNESS_EN.
- Defined:
  - The streak counter increments on each CPU grant made while COP is pending.
  - It resets to 0 on any COP grant, or when COP is not pending at grant time.
  - When streak = MAX_CPU_STREAK and COP is pending, the next grant goes to COP even if CPU is pending.
- Undefined: strict CPU priority; the streak counter is absent and COP may starve.

Decomposition:
- Package rom_arb_pkg holds:
  - State enum {IDLE, ACCESS, DONE}.
  - Requester id constants REQ_CPU = 0, REQ_COP = 1.
  - Holding-register struct {addr[23:0], word, we_n, d[15:0]}.
- Sub-module rom_arb_slot is instantiated twice. It contains the capture logic, pending flag and holding register, and outputs pending and the held fields.

Test Plan:
- CPU byte read, addr=24'h008001, rom_mask=24'h0FFFFF, mem_q=16'hA55A, MEM_LAT=4 -> mem_addr=24'h008001, mem_ce_n/oe_n low for 4 cycles; cpu_ack 6 cycles after req; cpu_q=16'h00A5.
- COP word write, addr=24'h123456, d=16'hBEEF, rom_mask=24'h3FFFFF -> mem_we_n=0 for 4 cycles, mem_d=16'hBEEF, mem_word=1; cop_ack pulses; cop_q unchanged.
- cpu_req and cop_req in the same cycle -> CPU access first, cpu_ack at +6, cop_ack at +12; exactly one mem_ce_n low window per access with one high cycle between.
- cpu_req repeated while CPU pending -> second pulse ignored; a single access uses the first address.
- rst_n low during ACCESS cycle 2 -> next edge: strobes high, no ack, pending cleared; fresh req after reset serviced normally.
- ROM_ARB_FAIRNESS_EN, MAX_CPU_STREAK=3, CPU re-requests each ack, COP pending -> grant order CPU, CPU, CPU, COP, CPU.
